// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer engine.
package spi_pkg;

  localparam int unsigned DefDataWidth       = 8;
  localparam int unsigned DefClkDividerWidth = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // SPI mode encodings as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period divider, SCLK register and edge counter.
// Strobes are combinational and mark the PCLK edge on which SCLK toggles.
module spi_sclk_gen import spi_pkg::*; #(
  parameter int unsigned DATA_WIDTH        = DefDataWidth,
  parameter int unsigned CLK_DIVIDER_WIDTH = DefClkDividerWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         active_i,
  input  logic                         cpol_i,
  input  logic                         cpol_shadow_i,
  input  logic [CLK_DIVIDER_WIDTH-1:0] div_load_i,
  input  logic [CLK_DIVIDER_WIDTH-1:0] div_reload_i,
  output logic                         sclk_o,
  output logic                         lead_stb_o,
  output logic                         trail_stb_o,
  output logic                         last_stb_o
);

  localparam int unsigned EdgeW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_WIDTH - 1);

  logic [CLK_DIVIDER_WIDTH-1:0] div_cnt_d, div_cnt_q;
  logic [EdgeW-1:0]             edge_cnt_d, edge_cnt_q;
  logic                         sclk_d, sclk_q;
  logic                         tick;

  // Divider and edge bookkeeping; sclk follows cpol while idle
  always_comb begin
    tick       = active_i && (div_cnt_q == '0);
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    if (!active_i) begin
      sclk_d     = cpol_i;
      edge_cnt_d = '0;
      div_cnt_d  = start_i ? div_load_i : '0;
    end else if (tick) begin
      // Final edge lands on the latched idle level by construction
      sclk_d     = (edge_cnt_q == LastEdge) ? cpol_shadow_i : ~sclk_q;
      div_cnt_d  = div_reload_i;
      edge_cnt_d = edge_cnt_q + 1'b1;
    end else begin
      div_cnt_d = div_cnt_q - 1'b1;
    end
  end

  // Toggle numbering starts at 1: an even count before the tick means a leading edge
  always_comb begin
    lead_stb_o  = tick && !edge_cnt_q[0];
    trail_stb_o = tick && edge_cnt_q[0];
    last_stb_o  = tick && (edge_cnt_q == LastEdge);
    sclk_o      = sclk_q;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_xfer_engine.sv
// Full-duplex SPI shift engine: one transfer per rising edge of go.
module spi_xfer_engine import spi_pkg::*; #(
  parameter int unsigned DATA_WIDTH        = DefDataWidth,
  parameter int unsigned CLK_DIVIDER_WIDTH = DefClkDividerWidth
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         go,
  input  logic                         cpol,
  input  logic                         cpha,
  input  logic [CLK_DIVIDER_WIDTH-1:0] clk_divider,
  input  logic [DATA_WIDTH-1:0]        datai,
  output logic [DATA_WIDTH-1:0]        datao,
  output logic                         busy,
  output logic                         done,
  input  logic                         miso,
  output logic                         mosi,
  output logic                         sclk
);

  state_e                       state_d, state_q;
  logic                         go_q;
  logic                         cpol_d, cpol_q, cpha_d, cpha_q;
  logic [CLK_DIVIDER_WIDTH-1:0] div_d, div_q;
  logic [DATA_WIDTH-1:0]        tx_d, tx_q, rx_d, rx_q, rx_shift;
  logic [DATA_WIDTH-1:0]        datao_d, datao_q;
  logic                         mosi_d, mosi_q, done_d, done_q;
  logic                         start, sample, drive;
  logic                         lead_stb, trail_stb, last_stb;

  assign start = go && !go_q && (state_q == IDLE);

  spi_sclk_gen #(
    .DATA_WIDTH       (DATA_WIDTH),
    .CLK_DIVIDER_WIDTH(CLK_DIVIDER_WIDTH)
  ) u_sclk_gen (
    .clk_i        (PCLK),
    .rst_ni       (PRESETn),
    .start_i      (start),
    .active_i     (state_q == SHIFT),
    .cpol_i       (cpol),
    .cpol_shadow_i(cpol_q),
    .div_load_i   (clk_divider),
    .div_reload_i (div_q),
    .sclk_o       (sclk),
    .lead_stb_o   (lead_stb),
    .trail_stb_o  (trail_stb),
    .last_stb_o   (last_stb)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_stb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shadows, tx/rx shift registers, mosi and completion
  always_comb begin
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    div_d    = div_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    datao_d  = datao_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    rx_shift = {rx_q[DATA_WIDTH-2:0], miso};
    sample   = cpha_q ? trail_stb : lead_stb;
    // cpha=0 never drives after the final trailing edge
    drive    = cpha_q ? lead_stb : (trail_stb && !last_stb);
    if (state_q == IDLE) begin
      mosi_d = 1'b0;
      if (start) begin
        cpol_d = cpol;
        cpha_d = cpha;
        div_d  = clk_divider;
        rx_d   = '0;
        // cpha=0 presents the MSB now, so keep only the remaining bits queued
        if (!cpha) begin
          mosi_d = datai[DATA_WIDTH-1];
          tx_d   = datai << 1;
        end else begin
          tx_d   = datai;
        end
      end
    end else begin
      if (sample) rx_d = rx_shift;
      if (drive) begin
        mosi_d = tx_q[DATA_WIDTH-1];
        tx_d   = tx_q << 1;
      end
      if (last_stb) begin
        datao_d = sample ? rx_shift : rx_q;
        done_d  = 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    busy  = (state_q == SHIFT);
    done  = done_q;
    datao = datao_q;
    mosi  = mosi_q;
  end

  // State registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      datao_q <= '0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      datao_q <= datao_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine: vector table plus hand-written corner sequences.
module tb_spi_xfer_engine;
  import spi_pkg::*;

  logic       PCLK, PRESETn, go, cpol, cpha, miso, mosi, sclk, busy, done;
  logic [7:0] clk_divider, datai, datao;
  logic       loop_en;
  logic [7:0] slv_sh;
  int         checks, errors;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] cd;
    logic [7:0] tx;
    logic [7:0] slv;
    logic       loop;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  spi_xfer_engine #(
    .DATA_WIDTH       (8),
    .CLK_DIVIDER_WIDTH(8)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .go         (go),
    .cpol       (cpol),
    .cpha       (cpha),
    .clk_divider(clk_divider),
    .datai      (datai),
    .datao      (datao),
    .busy       (busy),
    .done       (done),
    .miso       (miso),
    .mosi       (mosi),
    .sclk       (sclk)
  );

  assign miso = loop_en ? mosi : slv_sh[7];

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One transfer with a bench-side slave that shifts on trailing SCLK edges.
  // abort_at>0 returns right after that SCLK edge; chg_at>0 scrambles inputs mid-transfer.
  task automatic run_vec(input vec_t v, input int abort_at, input int chg_at);
    int         cyc, busy_cnt, edges, bitn, limit, half;
    logic       sclk_prev, lead, mcpol, mcpha;
    logic [7:0] mtx;
    @(negedge PCLK);
    {cpol, cpha} = v.mode;
    clk_divider  = v.cd;
    datai        = v.tx;
    loop_en      = v.loop;
    slv_sh       = v.slv;
    mcpol        = v.mode[1];
    mcpha        = v.mode[0];
    mtx          = v.tx;
    half         = int'(v.cd) + 1;
    limit        = 16 * half + 8;
    @(negedge PCLK);
    @(negedge PCLK);
    chk1("idle_sclk", sclk, mcpol);
    chk1("idle_mosi", mosi, 1'b0);
    go        = 1'b1;
    sclk_prev = sclk;
    cyc = 0; busy_cnt = 0; edges = 0; bitn = 0;
    while (1) begin
      @(negedge PCLK);
      cyc++;
      if (cyc == 1) go = 1'b0;
      if (cyc == chg_at) begin
        cpol        = ~cpol;
        cpha        = ~cpha;
        clk_divider = clk_divider + 8'd3;
        datai       = ~datai;
      end
      if (busy) busy_cnt++;
      if (sclk !== sclk_prev && edges < 16) begin
        lead = (sclk != mcpol);
        if (lead != mcpha) begin
          if (bitn < 8) chk1("mosi_bit", mosi, mtx[3'(7 - bitn)]);
          bitn++;
        end
        if (!lead) slv_sh = slv_sh << 1;
        edges++;
      end
      sclk_prev = sclk;
      if (abort_at != 0 && edges == abort_at) return;
      if (done || cyc > limit) break;
    end
    chk1("done_seen", done, 1'b1);
    chkn("done_latency", cyc, 16 * half + 1);
    chkn("busy_cycles", busy_cnt, 16 * half);
    chkn("sclk_edges", edges, 16);
    chk8("datao", datao, v.exp);
    chk1("sclk_end_level", sclk, mcpol);
    @(negedge PCLK);
    chk1("done_width", done, 1'b0);
    chk1("busy_after", busy, 1'b0);
    chk1("mosi_return", mosi, 1'b0);
  endtask

  initial begin
    int   dones;
    vec_t rv;
    checks  = 0;
    errors  = 0;
    PRESETn = 1'b0;
    go      = 1'b0;
    cpol    = 1'b1;
    cpha    = 1'b0;
    clk_divider = 8'd0;
    datai   = 8'd0;
    loop_en = 1'b0;
    slv_sh  = 8'd0;

    vecs[0] = '{mode: MODE0, cd: 8'd0,   tx: 8'hA5, slv: 8'h00, loop: 1'b1, exp: 8'hA5};
    vecs[1] = '{mode: MODE3, cd: 8'd3,   tx: 8'h3C, slv: 8'hC3, loop: 1'b0, exp: 8'hC3};
    vecs[2] = '{mode: MODE1, cd: 8'd1,   tx: 8'h81, slv: 8'h7E, loop: 1'b0, exp: 8'h7E};
    vecs[3] = '{mode: MODE2, cd: 8'd1,   tx: 8'h81, slv: 8'h7E, loop: 1'b0, exp: 8'h7E};
    vecs[4] = '{mode: MODE0, cd: 8'd2,   tx: 8'h00, slv: 8'hFF, loop: 1'b0, exp: 8'hFF};
    vecs[5] = '{mode: MODE1, cd: 8'd0,   tx: 8'hFF, slv: 8'h00, loop: 1'b0, exp: 8'h00};
    vecs[6] = '{mode: MODE3, cd: 8'hFF,  tx: 8'h96, slv: 8'h69, loop: 1'b0, exp: 8'h69};

    // Reset values, including sclk=0 even though cpol=1
    repeat (3) @(negedge PCLK);
    chk1("rst_sclk", sclk, 1'b0);
    chk1("rst_mosi", mosi, 1'b0);
    chk8("rst_datao", datao, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk1("idle_track_cpol1", sclk, 1'b1);
    cpol = 1'b0;
    @(negedge PCLK);
    chk1("idle_track_cpol0", sclk, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 0, 0);

    // go held high with a second rising edge while busy: exactly one transfer
    @(negedge PCLK);
    {cpol, cpha} = MODE0;
    clk_divider  = 8'd0;
    datai        = 8'h3C;
    loop_en      = 1'b1;
    @(negedge PCLK);
    go    = 1'b1;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if (done) dones++;
      if (i == 4) go = 1'b0;
      if (i == 6) go = 1'b1;
    end
    go = 1'b0;
    chkn("go_held_dones", dones, 1);
    chk8("go_held_datao", datao, 8'h3C);

    // Config/data changes mid-transfer are ignored; next transfer uses new values
    rv = '{mode: MODE0, cd: 8'd1, tx: 8'h5A, slv: 8'h96, loop: 1'b0, exp: 8'h96};
    run_vec(rv, 0, 5);
    rv = '{mode: MODE2, cd: 8'd1, tx: 8'h0F, slv: 8'h33, loop: 1'b0, exp: 8'h33};
    run_vec(rv, 0, 0);

    // Asynchronous reset right after SCLK edge 7
    rv = '{mode: MODE0, cd: 8'd1, tx: 8'hC3, slv: 8'h55, loop: 1'b0, exp: 8'h55};
    run_vec(rv, 7, 0);
    #2 PRESETn = 1'b0;
    #1;
    chk1("abort_sclk", sclk, 1'b0);
    chk1("abort_mosi", mosi, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk8("abort_datao", datao, 8'h00);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      if (done) dones++;
    end
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      if (done) dones++;
    end
    chkn("abort_no_done", dones, 0);
    rv = '{mode: MODE1, cd: 8'd2, tx: 8'hE7, slv: 8'h18, loop: 1'b0, exp: 8'h18};
    run_vec(rv, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
